vga_controller: RTL and testbench
=================================

# vga_controller

Timing generator and pixel gate for a 640x480 at 60 Hz VGA output driving an ADV7123-style video DAC. It runs on the 25.175 MHz pixel clock from the video PLL. It publishes the coordinate of the pixel being scanned so the frame-buffer logic (SRAM address generator) can fetch it, then gates the returned colour onto the DAC outputs with sync and blank. Sits between the frame-buffer controller and the board VGA pins.

## Interface
Parameters:
- H_SYNC_LEN, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC_LEN, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACT, 480, active lines
- V_FRONT, 10, vertical front porch
- CURSOR_X, 320, crosshair column (used only with VGA_CURSOR_EN)
- CURSOR_Y, 240, crosshair row (used only with VGA_CURSOR_EN)

Ports:
- iCLK  in  1  pixel clock; all state on its rising edge
- iRST  in  1  reset, asynchronous, active-high
- iCursor_RGB_EN  in  4  [2]=red, [1]=green, [0]=blue channel enable; [3]=cursor enable
- iRed / iGreen / iBlue  in  10 each  pixel colour for the coordinate currently on oCoord_X/oCoord_Y
- oCoord_X  out  10  active-area column 0..639; 0 outside active area
- oCoord_Y  out  10  active-area row 0..479; 0 outside active area
- oVGA_R / oVGA_G / oVGA_B  out  10 each  DAC colour
- oVGA_H_SYNC  out  1  horizontal sync, active-low
- oVGA_V_SYNC  out  1  vertical sync, active-low
- oVGA_SYNC  out  1  DAC sync-on-green control, constant 0
- oVGA_BLANK  out  1  DAC blank_n: 1 in active area, 0 otherwise

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters = 800.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - h_cnt wraps from 799 to 0. v_cnt advances by one on each h_cnt wrap, and wraps from 524 to 0 together with the h_cnt wrap.
- Decode from the counter values:
  - hsync_n = (h_cnt >= H_SYNC_LEN); vsync_n = (v_cnt >= V_SYNC_LEN).
  - h_act = h_cnt in [144, 784); v_act = v_cnt in [35, 515); active = h_act & v_act.
  - Coordinates = (h_cnt-144, v_cnt-35) when active, else (0, 0). Subtraction is truncated to 10 bits.
- Sync, blank and coordinates are registered from this decode (see Timing).
- Colour path is combinational from the iRed/iGreen/iBlue inputs, so that asynchronous SRAM read data reaches the DAC in the same cycle:
  - oVGA_R = (oVGA_BLANK & iCursor_RGB_EN[2]) ? iRed : 0. Green uses bit [1], blue uses bit [0].
- oVGA_SYNC is tied to 0.
- Reset values:
  - Counters 0.
  - oVGA_H_SYNC = 1, oVGA_V_SYNC = 1, oVGA_BLANK = 0, oCoord_X = 0, oCoord_Y = 0.
  - Colour outputs are therefore 0 during reset.
- Reset asserted mid-frame: all state returns to the reset values immediately. The frame restarts from (h_cnt, v_cnt) = (0, 0) after release. No partial-line recovery.

## Timing
- One registered stage. At each rising edge, the outputs take the decode of the counter value held before the edge, and the counters advance.
- On the first edge after reset release, the outputs show the decode of count (0, 0): H_SYNC = 0, V_SYNC = 0, BLANK = 0.
- From that edge on, outputs follow the counters with exactly one clock of latency.
- Line period 800 clocks. H_SYNC is low for 96 clocks. BLANK is high for 640 consecutive clocks per active line.
- Frame period 525 lines = 420000 clocks. V_SYNC is low for 2 full lines (1600 clocks).
- oCoord_X increments by 1 each clock across the active line: 0..639. oCoord_Y is constant within a line.
- Colour: iRed sampled against the current oCoord value appears on oVGA_R in the same cycle, with no added latency.

## Configuration
- Macro VGA_CURSOR_EN.
- When defined:
  - If iCursor_RGB_EN[3] = 1 and active, pixels with oCoord_X == CURSOR_X or oCoord_Y == CURSOR_Y drive all three colour outputs to 10'h3FF. This override ignores the channel enables.
  - If iCursor_RGB_EN[3] = 0, colour behaves as without the macro.
- When undefined:
  - iCursor_RGB_EN[3] is ignored.
  - No crosshair logic is synthesised.

## Test plan
- Reset held 10 clocks, then released: during reset H_SYNC = 1, V_SYNC = 1, BLANK = 0, coords 0, colour 0. The first post-release edge gives H_SYNC = 0.
- Free-run 2 frames: H_SYNC falling edges are 800 clocks apart with a 96-clock low width. V_SYNC falling edges are 420000 clocks apart with a 1600-clock low width. BLANK is high for 640x480 = 307200 clocks per frame.
- Active-area coordinates: first BLANK-high clock has coords (0, 0); last BLANK-high clock of the frame has (639, 479). Coords are 0 whenever BLANK = 0.
- iRed = 10'h3C0, iGreen = 10'h0F0, iBlue = 10'h00F with iCursor_RGB_EN = 4'b0111: outputs are 3C0/0F0/00F while BLANK = 1 and 0 while BLANK = 0. With iCursor_RGB_EN = 4'b0101, oVGA_G = 0 throughout.
- Assert iRST mid-line (h_cnt ~ 400, v_cnt ~ 200) for 3 clocks: outputs immediately take the reset values. After release, the next V_SYNC falling edge occurs 1 clock after release, since the frame restarts from (0, 0).
- With VGA_CURSOR_EN and iCursor_RGB_EN = 4'b1000 (channel enables off, cursor on), inputs all 0: outputs are 3FF on column 320 and row 240 only, and 0 elsewhere.

Source files
------------

// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator with combinational colour gate for an ADV7123-style DAC.
// Optional crosshair overlay is enabled with the VGA_CURSOR_EN macro.
module vga_controller #(
   parameter int H_SYNC_LEN = 96,
   parameter int H_BACK     = 48,
   parameter int H_ACT      = 640,
   parameter int H_FRONT    = 16,
   parameter int V_SYNC_LEN = 2,
   parameter int V_BACK     = 33,
   parameter int V_ACT      = 480,
   parameter int V_FRONT    = 10,
   parameter int CURSOR_X   = 320,
   parameter int CURSOR_Y   = 240
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [3:0] iCursor_RGB_EN,
   input  logic [9:0] iRed,
   input  logic [9:0] iGreen,
   input  logic [9:0] iBlue,
   output logic [9:0] oCoord_X,
   output logic [9:0] oCoord_Y,
   output logic [9:0] oVGA_R,
   output logic [9:0] oVGA_G,
   output logic [9:0] oVGA_B,
   output logic       oVGA_H_SYNC,
   output logic       oVGA_V_SYNC,
   output logic       oVGA_SYNC,
   output logic       oVGA_BLANK
);

   localparam logic [9:0] H_LAST   = 10'(H_SYNC_LEN + H_BACK + H_ACT + H_FRONT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_SYNC_LEN + V_BACK + V_ACT + V_FRONT - 1);
   localparam logic [9:0] H_SYNC_E = 10'(H_SYNC_LEN);
   localparam logic [9:0] V_SYNC_E = 10'(V_SYNC_LEN);
   localparam logic [9:0] H_ACT_S  = 10'(H_SYNC_LEN + H_BACK);
   localparam logic [9:0] H_ACT_E  = 10'(H_SYNC_LEN + H_BACK + H_ACT);
   localparam logic [9:0] V_ACT_S  = 10'(V_SYNC_LEN + V_BACK);
   localparam logic [9:0] V_ACT_E  = 10'(V_SYNC_LEN + V_BACK + V_ACT);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [9:0] coord_x_q, coord_x_d;
   logic [9:0] coord_y_q, coord_y_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       blank_q, blank_d;
   logic       h_act, v_act;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
      h_act     = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
      v_act     = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
      hsync_d   = (h_cnt_q >= H_SYNC_E);
      vsync_d   = (v_cnt_q >= V_SYNC_E);
      blank_d   = h_act && v_act;
      coord_x_d = blank_d ? (h_cnt_q - H_ACT_S) : '0;
      coord_y_d = blank_d ? (v_cnt_q - V_ACT_S) : '0;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         coord_x_q <= '0;
         coord_y_q <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         blank_q   <= 1'b0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         coord_x_q <= coord_x_d;
         coord_y_q <= coord_y_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         blank_q   <= blank_d;
      end
   end

   assign oCoord_X    = coord_x_q;
   assign oCoord_Y    = coord_y_q;
   assign oVGA_H_SYNC = hsync_q;
   assign oVGA_V_SYNC = vsync_q;
   assign oVGA_BLANK  = blank_q;
   assign oVGA_SYNC   = 1'b0;

`ifdef VGA_CURSOR_EN
   localparam logic [9:0] CUR_X = 10'(CURSOR_X);
   localparam logic [9:0] CUR_Y = 10'(CURSOR_Y);
`else
   logic cursor_unused;
   assign cursor_unused = ^{iCursor_RGB_EN[3], 10'(CURSOR_X), 10'(CURSOR_Y)};
`endif

   // Colour stays combinational so asynchronous SRAM data reaches the DAC in the same cycle.
   always_comb begin
      oVGA_R = (blank_q && iCursor_RGB_EN[2]) ? iRed   : '0;
      oVGA_G = (blank_q && iCursor_RGB_EN[1]) ? iGreen : '0;
      oVGA_B = (blank_q && iCursor_RGB_EN[0]) ? iBlue  : '0;
`ifdef VGA_CURSOR_EN
      if (blank_q && iCursor_RGB_EN[3] && (coord_x_q == CUR_X || coord_y_q == CUR_Y)) begin
         oVGA_R = 10'h3FF;
         oVGA_G = 10'h3FF;
         oVGA_B = 10'h3FF;
      end
`endif
   end

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller using a reduced raster (32 x 13 clocks per frame).
// Expected outputs are pushed at each rising edge and checked by a monitor on the falling edge.
module tb_vga_controller;

   // Reduced timing: H 8/4/16/4 = 32 clocks, V 2/3/6/2 = 13 lines, frame = 416 clocks.
   localparam int HS = 8, HB = 4, HA = 16, HF = 4;
   localparam int VS = 2, VB = 3, VA = 6, VF = 2;
   localparam int CX = 5, CY = 3;
   localparam int H_TOT = 32, FRAME = 416, VS_LOW = 64, BLANK_PER_FRAME = 96;
   localparam int ACT_H0 = 12, ACT_H1 = 28, ACT_V0 = 5, ACT_V1 = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] en  = 4'b0111;
   logic [9:0] i_r = 10'h3C0, i_g = 10'h0F0, i_b = 10'h00F;
   logic [9:0] cx, cy, vr, vg, vb;
   logic       hs, vs, sync, blank;

   vga_controller #(
      .H_SYNC_LEN(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
      .V_SYNC_LEN(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
      .CURSOR_X(CX), .CURSOR_Y(CY)
   ) dut (
      .iCLK(clk), .iRST(rst), .iCursor_RGB_EN(en),
      .iRed(i_r), .iGreen(i_g), .iBlue(i_b),
      .oCoord_X(cx), .oCoord_Y(cy),
      .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
      .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_SYNC(sync), .oVGA_BLANK(blank)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       hs;
      logic       vs;
      logic       blank;
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, x: 10'd0, y: 10'd0};

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference raster: each edge publishes the decode of the count held before it.
   int m_h = 0, m_v = 0;
   always @(posedge clk) begin
      exp_t e;
      if (rst) begin
         m_h = 0;
         m_v = 0;
         exp_q.push_back(RST_EXP);
      end else begin
         e.hs    = (m_h >= HS);
         e.vs    = (m_v >= VS);
         e.blank = (m_h >= ACT_H0 && m_h < ACT_H1 && m_v >= ACT_V0 && m_v < ACT_V1);
         e.x     = e.blank ? 10'(m_h - ACT_H0) : 10'd0;
         e.y     = e.blank ? 10'(m_v - ACT_V0) : 10'd0;
         exp_q.push_back(e);
         if (m_h == H_TOT - 1) begin
            m_h = 0;
            m_v = (m_v == 12) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
      end
   end

   // Monitor: pops one expectation per cycle, plus sync/blank interval measurements.
   logic meas_en = 1'b0;
   logic prev_hs = 1'b1, prev_vs = 1'b1;
   logic hs_seen = 1'b0, vs_seen = 1'b0, first_pend = 1'b0;
   int   cyc = 0, hs_t = 0, vs_t = 0, blank_cnt = 0;
   logic [9:0] last_x = '0, last_y = '0;

   always @(negedge clk) begin
      exp_t e;
      logic [9:0] er, eg, eb;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rst) e = RST_EXP;
         er = (e.blank && en[2]) ? i_r : 10'd0;
         eg = (e.blank && en[1]) ? i_g : 10'd0;
         eb = (e.blank && en[0]) ? i_b : 10'd0;
`ifdef VGA_CURSOR_EN
         if (e.blank && en[3] && (e.x == 10'(CX) || e.y == 10'(CY))) begin
            er = 10'h3FF; eg = 10'h3FF; eb = 10'h3FF;
         end
`endif
         check("hsync", hs, e.hs);
         check("vsync", vs, e.vs);
         check("blank", blank, e.blank);
         check("coord_x", cx, e.x);
         check("coord_y", cy, e.y);
         check("red", vr, er);
         check("green", vg, eg);
         check("blue", vb, eb);
         check("sync_tie", sync, 1'b0);
      end
      if (meas_en) begin
         if (prev_hs && !hs) begin
            if (hs_seen) check("h_period", cyc - hs_t, H_TOT);
            hs_seen = 1'b1;
            hs_t    = cyc;
         end
         if (!prev_hs && hs && hs_seen) check("h_low_width", cyc - hs_t, HS);
         if (prev_vs && !vs) begin
            if (vs_seen) begin
               check("v_period", cyc - vs_t, FRAME);
               check("blank_per_frame", blank_cnt, BLANK_PER_FRAME);
               check("last_x", last_x, 15);
               check("last_y", last_y, 5);
            end
            vs_seen    = 1'b1;
            vs_t       = cyc;
            blank_cnt  = 0;
            first_pend = 1'b1;
         end
         if (!prev_vs && vs && vs_seen) check("v_low_width", cyc - vs_t, VS_LOW);
         if (blank) begin
            blank_cnt++;
            last_x = cx;
            last_y = cy;
            if (first_pend) begin
               check("first_x", cx, 0);
               check("first_y", cy, 0);
               first_pend = 1'b0;
            end
         end
      end
      prev_hs = hs;
      prev_vs = vs;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      int   hits;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      meas_en = 1'b1;
      @(posedge clk); #1;
      check("first_edge_hsync", hs, 1'b0);
      check("first_edge_vsync", vs, 1'b0);
      check("first_edge_blank", blank, 1'b0);

      // Two full frames with all channels enabled.
      repeat (2 * FRAME + 40) @(posedge clk);
      #2;
      meas_en = 1'b0;
      en = 4'b0101;
      repeat (FRAME) @(posedge clk);

      // Land mid-line inside the active area, then pulse reset.
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(posedge clk); #2;
         found = (blank && cx == 10'd8 && cy == 10'd2);
      end
      check("reset_point_reached", found, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_hsync", hs, 1'b1);
      check("async_rst_vsync", vs, 1'b1);
      check("async_rst_blank", blank, 1'b0);
      check("async_rst_x", cx, 0);
      check("async_rst_y", cy, 0);
      check("async_rst_red", vr, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      en  = 4'b1000;
      i_r = '0; i_g = '0; i_b = '0;

      // Restarted frame: V_SYNC falls on the first edge; count crosshair pixels.
      hits = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (i == 0) check("vsync_before_restart", vs, 1'b1);
         if (i == 1) check("vsync_fall_after_rst", vs, 1'b0);
         if (vr == 10'h3FF) hits++;
      end
`ifdef VGA_CURSOR_EN
      check("cursor_pixels", hits, 21);
`else
      check("cursor_pixels", hits, 0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
